// File: rtl/ram_bist_ctrl_pkg.sv
// Shared definitions for the RAM BIST controller: FSM state encoding,
// default march seed and error counter width.
package ram_bist_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_W_UP   = 3'd1;
    localparam logic [2:0] ST_R_UP   = 3'd2;
    localparam logic [2:0] ST_DRAIN0 = 3'd3;
    localparam logic [2:0] ST_W_DN   = 3'd4;
    localparam logic [2:0] ST_R_DN   = 3'd5;
    localparam logic [2:0] ST_DRAIN1 = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_W_UP   = ST_W_UP,
        S_R_UP   = ST_R_UP,
        S_DRAIN0 = ST_DRAIN0,
        S_W_DN   = ST_W_DN,
        S_R_DN   = ST_R_DN,
        S_DRAIN1 = ST_DRAIN1,
        S_DONE   = ST_DONE
    } bist_state_t;

    localparam logic [7:0] BIST_PATTERN = 8'hA5;
    localparam int         ERR_W        = 8;

endpackage

// File: rtl/ram_bist_ctrl_cmp_pipe.sv
// Read-compare pipeline: delays expected data/address/phase by the RAM read
// latency, compares against data_out and tracks first failure and error count.
module bist_cmp_pipe
    import ram_bist_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              flush,
    input  logic              rd_vld,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic              rd_phase,
    input  logic [DATA_W-1:0] data_out,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              fail_phase
);

    logic [READ_LAT-1:0]             vld_p;
    logic [READ_LAT-1:0][DATA_W-1:0] exp_p;
    logic [READ_LAT-1:0][ADDR_W-1:0] addr_p;
    logic [READ_LAT-1:0]             phase_p;
    logic                            mismatch;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    // Aborted or restarted runs must not let a stale read reach the counter.
    assign mismatch = vld_p[READ_LAT-1] && (data_out != exp_p[READ_LAT-1])
                      && !flush && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p      <= '0;
            exp_p      <= '0;
            addr_p     <= '0;
            phase_p    <= '0;
            err_count  <= '0;
            fail_addr  <= '0;
            fail_phase <= 1'b0;
        end else begin
            exp_p[0]   <= rd_exp;
            addr_p[0]  <= rd_addr;
            phase_p[0] <= rd_phase;
            for (int i = 1; i < READ_LAT; i++) begin
                exp_p[i]   <= exp_p[i-1];
                addr_p[i]  <= addr_p[i-1];
                phase_p[i] <= phase_p[i-1];
            end
            if (clr || flush) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= rd_vld;
                for (int i = 1; i < READ_LAT; i++) begin
                    vld_p[i] <= vld_p[i-1];
                end
            end

            if (clr) begin
                err_count  <= '0;
                fail_addr  <= '0;
                fail_phase <= 1'b0;
            end else if (mismatch) begin
                err_count <= sat_inc(err_count);
                if (err_count == '0) begin
                    fail_addr  <= addr_p[READ_LAT-1];
                    fail_phase <= phase_p[READ_LAT-1];
                end
            end
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-test BIST initiator for a synchronous dual-port RAM: FSM, address
// counter and registered RAM-side strobes; compare logic lives in bist_cmp_pipe.
module ram_bist_ctrl
    import ram_bist_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 16,
    parameter int                READ_LAT = 1,
    parameter logic [DATA_W-1:0] PATTERN  = DATA_W'(BIST_PATTERN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic              we,
    output logic              re,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              fail_phase,
    output logic [ERR_W-1:0]  err_count
);

    localparam int                DRN_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(READ_LAT - 1);

    bist_state_t       state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [DRN_W-1:0]  drn, drn_nxt;
    logic              run_clr;
    logic              flush;
    logic              we_nxt, re_nxt, busy_nxt;

    function automatic logic [DATA_W-1:0] march_data(input logic [ADDR_W-1:0] a,
                                                     input logic inv);
        logic [DATA_W-1:0] d;
        d = DATA_W'(a) ^ PATTERN;
        return inv ? ~d : d;
    endfunction

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        drn_nxt   = drn;
        run_clr   = 1'b0;
        flush     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_W_UP;
                    addr_nxt  = '0;
                    drn_nxt   = '0;
                    run_clr   = 1'b1;
                end
            end
            S_W_UP: begin
                if (addr == ADDR_LAST) begin
                    state_nxt = S_R_UP;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            S_R_UP: begin
                if (addr == ADDR_LAST) begin
                    state_nxt = S_DRAIN0;
                    drn_nxt   = '0;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            S_DRAIN0: begin
                if (drn == DRN_LAST) begin
                    state_nxt = S_W_DN;
                    addr_nxt  = ADDR_LAST;
                end else begin
                    drn_nxt = drn + 1'b1;
                end
            end
            S_W_DN: begin
                if (addr == '0) begin
                    state_nxt = S_R_DN;
                    addr_nxt  = ADDR_LAST;
                end else begin
                    addr_nxt = addr - 1'b1;
                end
            end
            S_R_DN: begin
                if (addr == '0) begin
                    state_nxt = S_DRAIN1;
                    drn_nxt   = '0;
                end else begin
                    addr_nxt = addr - 1'b1;
                end
            end
            S_DRAIN1: begin
                if (drn == DRN_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    drn_nxt = drn + 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            flush     = 1'b1;
        end
    end

    // RAM strobes are registered from the next state so they stay aligned with state.
    assign we_nxt   = (state_nxt == S_W_UP) || (state_nxt == S_W_DN);
    assign re_nxt   = (state_nxt == S_R_UP) || (state_nxt == S_R_DN);
    assign busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr    <= '0;
            drn     <= '0;
            we      <= 1'b0;
            re      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            waddr   <= '0;
            raddr   <= '0;
            data_in <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            drn   <= drn_nxt;
            we    <= we_nxt;
            re    <= re_nxt;
            busy  <= busy_nxt;
            if (run_clr) begin
                done <= 1'b0;
            end else if (state_nxt == S_DONE) begin
                done <= 1'b1;
            end
            if (we_nxt) begin
                waddr   <= addr_nxt;
                data_in <= march_data(addr_nxt, state_nxt == S_W_DN);
            end
            if (re_nxt) begin
                raddr <= addr_nxt;
            end
        end
    end

    // err_count settles in the DONE cycle, so pass is qualified from live flops.
    assign pass = done && (err_count == '0);

    bist_cmp_pipe #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (run_clr),
        .flush      (flush),
        .rd_vld     (re),
        .rd_addr    (raddr),
        .rd_exp     (march_data(raddr, state == S_R_DN)),
        .rd_phase   (state == S_R_DN),
        .data_out   (data_out),
        .err_count  (err_count),
        .fail_addr  (fail_addr),
        .fail_phase (fail_phase)
    );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl with a 16x8 RAM model and injectable faults.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] waddr, raddr, fail_addr;
    logic       we, re, busy, done, pass, fail_phase;
    logic [7:0] data_in, data_out, err_count;

    int fault = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [3:0] faddr;
        logic       fphase;
        int         busy_cycles;
    } res_t;

    wr_t  write_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;

    ram_bist_ctrl #(
        .ADDR_W   (4),
        .DATA_W   (8),
        .DEPTH    (16),
        .READ_LAT (1),
        .PATTERN  (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .waddr      (waddr),
        .raddr      (raddr),
        .we         (we),
        .re         (re),
        .data_in    (data_in),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_phase (fail_phase),
        .err_count  (err_count)
    );

    // RAM model; fault 1 = bit 3 stuck-at-1 at address 5, fault 2 = 11 aliases 3
    logic [7:0] mem [16];

    function automatic logic [3:0] map_a(input logic [3:0] a);
        return (fault == 2 && a == 4'd11) ? 4'd3 : a;
    endfunction

    always @(posedge clk) begin
        logic [7:0] d;
        if (we) mem[map_a(waddr)] <= data_in;
        if (re) begin
            d = mem[map_a(raddr)];
            if (fault == 1 && raddr == 4'd5) d = d | 8'h08;
            data_out <= d;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_writes();
        wr_t w;
        for (int a = 0; a < 16; a++) begin
            w.a = 4'(a);
            w.d = 8'(a) ^ 8'hA5;
            write_q.push_back(w);
        end
        for (int a = 15; a >= 0; a--) begin
            w.a = 4'(a);
            w.d = ~(8'(a) ^ 8'hA5);
            write_q.push_back(w);
        end
    endtask

    task automatic push_res(input logic p, input logic [7:0] e, input logic [3:0] fa,
                            input logic fp);
        res_t r;
        r.pass = p; r.err = e; r.faddr = fa; r.fphase = fp; r.busy_cycles = 66;
        res_q.push_back(r);
    endtask

    // Returns at the negedge of the first busy cycle.
    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_timeout", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a result.
    int   busy_cnt = 0;
    logic busy_q = 1'b0;
    logic done_q = 1'b0;

    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        if (rst_n) begin
            if (we || re) check("we_re_exclusive", {31'd0, we && re}, 32'd0);
            if (busy) busy_cnt = busy_q ? busy_cnt + 1 : 1;
            busy_q = busy;
            if (we) begin
                if (write_q.size() == 0) begin
                    check("unexpected_write", {28'd0, waddr}, 32'hFFFF);
                end else begin
                    w = write_q.pop_front();
                    check("waddr", {28'd0, waddr}, {28'd0, w.a});
                    check("data_in", {24'd0, data_in}, {24'd0, w.d});
                end
            end
            if (done && !done_q) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    r = res_q.pop_front();
                    check("busy_cycles", busy_cnt, r.busy_cycles);
                    check("pass", {31'd0, pass}, {31'd0, r.pass});
                    check("err_count", {24'd0, err_count}, {24'd0, r.err});
                    check("fail_addr", {28'd0, fail_addr}, {28'd0, r.faddr});
                    check("fail_phase", {31'd0, fail_phase}, {31'd0, r.fphase});
                end
            end
            done_q = done;
        end else begin
            busy_q = 1'b0;
            done_q = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_re", {31'd0, re}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        check("rst_waddr", {28'd0, waddr}, 32'd0);
        check("rst_data_in", {24'd0, data_in}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // clean run
        fault = 0;
        push_writes();
        push_res(1'b1, 8'd0, 4'd0, 1'b0);
        start_pulse();
        wait_done();

        // stuck bit 3 at address 5: only the A0 read fails
        fault = 1;
        push_writes();
        push_res(1'b0, 8'd1, 4'd5, 1'b0);
        start_pulse();
        wait_done();

        // addresses 3 and 11 aliased
        fault = 2;
        push_writes();
        push_res(1'b0, 8'd2, 4'd3, 1'b0);
        start_pulse();
        wait_done();

        // start re-pulsed at cycle 20 is ignored
        fault = 0;
        push_writes();
        push_res(1'b1, 8'd0, 4'd0, 1'b0);
        start_pulse();
        repeat (19) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done();

        // reset asserted at cycle 30
        push_writes();
        start_pulse();
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_we", {31'd0, we}, 32'd0);
        check("midrst_re", {31'd0, re}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_err", {24'd0, err_count}, 32'd0);
        write_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        push_writes();
        push_res(1'b1, 8'd0, 4'd0, 1'b0);
        start_pulse();
        wait_done();

        // abort in R_DN of a faulty run, then a clean run
        fault = 1;
        push_writes();
        start_pulse();
        repeat (54) @(negedge clk);
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        check("pre_abort_err", {24'd0, err_count}, 32'd1);
        check("pre_abort_faddr", {28'd0, fail_addr}, 32'd5);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {31'd0, we}, 32'd0);
        check("abort_re", {31'd0, re}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_writes_left", write_q.size(), 32'd0);
        write_q.delete();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        fault = 0;
        push_writes();
        push_res(1'b1, 8'd0, 4'd0, 1'b0);
        start_pulse();
        wait_done();

        check("writes_left", write_q.size(), 32'd0);
        check("results_left", res_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
